// File: rtl/bist_pkg.sv
// Shared definitions for the BIST sequencer: state encoding and default sizing.
// Both bist_counter and bist_sequencer import this package.
package bist_pkg;

   localparam int BIST_CNT_W       = 8;
   localparam int BIST_SEED_SW_DEF = 4;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARM  = 3'd1,
      S_INIT = 3'd2,
      S_RUN  = 3'd3,
      S_GAP  = 3'd4,
      S_DONE = 3'd5,
      S_HOLD = 3'd6,
      S_WAIT = 3'd7
   } state_t;

endpackage

// File: rtl/bist_counter.sv
// Pattern/phase counter pair for the BIST sequencer.
// pat wraps to 0 on its last count; phase advances only when asked to.
module bist_counter
   import bist_pkg::*;
#(
   parameter int CNT_W = BIST_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             phase_inc,
   input  logic [CNT_W-1:0] n_max,
   input  logic [CNT_W-1:0] m_max,
   output logic             pat_last,
   output logic             phase_last,
   output logic [CNT_W-1:0] phase
);

   logic [CNT_W-1:0] pat;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         pat   <= '0;
         phase <= '0;
      end else begin
         if (en) begin
            pat <= pat_last ? '0 : pat + 1'b1;
         end
         if (phase_inc) begin
            phase <= phase + 1'b1;
         end
      end
   end

   // Terminal counts compare against max-1 so a full-scale max never wraps.
   assign pat_last   = (pat == n_max - 1'b1);
   assign phase_last = (phase == m_max - 1'b1);

endmodule

// File: rtl/bist_sequencer.sv
// BIST session sequencer: runs M phases of N patterns with a one-cycle gap between.
// Optional abort support is compiled in with macro BIST_ABORT_EN.
//
// state | meaning
// IDLE  | after reset, waiting for START low
// ARM   | waiting for START high
// INIT  | one-cycle session start, config already latched
// RUN   | applying patterns (OUT=1)
// GAP   | one-cycle break between phases
// DONE  | one-cycle session end
// HOLD  | finished, waiting for START low
// WAIT  | finished, waiting for START high to rerun
module bist_sequencer
   import bist_pkg::*;
#(
   parameter int CNT_W       = BIST_CNT_W,
   parameter int SEED_SW_DEF = BIST_SEED_SW_DEF
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [CNT_W-1:0] N_CFG,
   input  logic [CNT_W-1:0] M_CFG,
   input  logic [CNT_W-1:0] SEED_SW,
`ifdef BIST_ABORT_EN
   input  logic             ABORT,
   output logic             ABORTED,
`endif
   output logic             INIT,
   output logic             RUNNING,
   output logic             OUT,
   output logic             SEED,
   output logic             FINISH,
   output logic             BIST_END,
   output logic [CNT_W-1:0] PHASE
);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] n_lat;
   logic [CNT_W-1:0] m_lat;
   logic [CNT_W-1:0] sw_lat;
   logic             ld;
   logic             cnt_en;
   logic             phase_inc;
   logic             pat_last;
   logic             phase_last;
   logic [CNT_W-1:0] phase;
`ifdef BIST_ABORT_EN
   logic             abort_hit;
`endif

   bist_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk        (CLK),
      .reset      (RESET),
      .clr        (ld),
      .en         (cnt_en),
      .phase_inc  (phase_inc),
      .n_max      (n_lat),
      .m_max      (m_lat),
      .pat_last   (pat_last),
      .phase_last (phase_last),
      .phase      (phase)
   );

   // Config is captured on the edge entering INIT so INIT can already branch on it.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state  <= S_IDLE;
         n_lat  <= '0;
         m_lat  <= '0;
         sw_lat <= CNT_W'(SEED_SW_DEF);
      end else begin
         state <= state_next;
         if (ld) begin
            n_lat  <= N_CFG;
            m_lat  <= M_CFG;
            sw_lat <= SEED_SW;
         end
      end
   end

   always_comb begin
      state_next = state;
      ld         = 1'b0;
      cnt_en     = 1'b0;
      phase_inc  = 1'b0;
      INIT       = 1'b0;
      RUNNING    = 1'b0;
      OUT        = 1'b0;
      SEED       = 1'b0;
      FINISH     = 1'b0;
      BIST_END   = 1'b0;
      PHASE      = phase;
`ifdef BIST_ABORT_EN
      abort_hit  = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (!START) state_next = S_ARM;
         end
         S_ARM: begin
            if (START) begin
               state_next = S_INIT;
               ld         = 1'b1;
            end
         end
         S_INIT: begin
            INIT       = 1'b1;
            state_next = (n_lat == '0 || m_lat == '0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            RUNNING = 1'b1;
            OUT     = 1'b1;
            SEED    = (phase >= sw_lat);
            cnt_en  = 1'b1;
            if (pat_last) state_next = S_GAP;
         end
         S_GAP: begin
            RUNNING = 1'b1;
            if (phase_last) begin
               state_next = S_DONE;
            end else begin
               state_next = S_RUN;
               phase_inc  = 1'b1;
            end
         end
         S_DONE: begin
            FINISH     = 1'b1;
            BIST_END   = 1'b1;
            state_next = S_HOLD;
         end
         S_HOLD: begin
            BIST_END = 1'b1;
            if (!START) state_next = S_WAIT;
         end
         S_WAIT: begin
            BIST_END = 1'b1;
            if (START) begin
               state_next = S_INIT;
               ld         = 1'b1;
            end
         end
         default: begin
            state_next = S_IDLE;
            PHASE      = '0;
         end
      endcase
`ifdef BIST_ABORT_EN
      if (ABORT && (state == S_RUN || state == S_GAP)) begin
         abort_hit  = 1'b1;
         state_next = S_DONE;
         cnt_en     = 1'b0;
         phase_inc  = 1'b0;
      end
`endif
   end

`ifdef BIST_ABORT_EN
   always_ff @(posedge CLK) begin
      if (RESET || ld) begin
         ABORTED <= 1'b0;
      end else if (abort_hit) begin
         ABORTED <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_bist_sequencer.sv
// Self-checking bench for bist_sequencer: per-cycle expected traces built from session rules.
// Define BIST_ABORT_EN to also exercise the abort port.
module tb_bist_sequencer;

   typedef logic [13:0] vec_t;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       START;
   logic [7:0] N_CFG;
   logic [7:0] M_CFG;
   logic [7:0] SEED_SW;
   logic       INIT;
   logic       RUNNING;
   logic       OUT;
   logic       SEED;
   logic       FINISH;
   logic       BIST_END;
   logic [7:0] PHASE;
`ifdef BIST_ABORT_EN
   logic       ABORT;
   logic       ABORTED;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   bist_sequencer #(
      .CNT_W       (8),
      .SEED_SW_DEF (4)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .START    (START),
      .N_CFG    (N_CFG),
      .M_CFG    (M_CFG),
      .SEED_SW  (SEED_SW),
`ifdef BIST_ABORT_EN
      .ABORT    (ABORT),
      .ABORTED  (ABORTED),
`endif
      .INIT     (INIT),
      .RUNNING  (RUNNING),
      .OUT      (OUT),
      .SEED     (SEED),
      .FINISH   (FINISH),
      .BIST_END (BIST_END),
      .PHASE    (PHASE)
   );

   // {INIT, RUNNING, OUT, SEED, FINISH, BIST_END, PHASE}
   function automatic vec_t mk(bit i, bit r, bit o, bit s, bit f, bit e, int ph);
      return {i, r, o, s, f, e, 8'(ph)};
   endfunction

   function automatic vec_t obs();
      return {INIT, RUNNING, OUT, SEED, FINISH, BIST_END, PHASE};
   endfunction

   task automatic check_vec(input string tag, input vec_t e);
      vec_t o;
      o = obs();
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic check_int(input string tag, input int o, input int e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
      end
   endtask

   // Called at a negedge in ARM or WAIT with START low; leaves the DUT in WAIT.
   task automatic session(input int n, input int m, input int sw, input int hold,
                          input bit toggle, input string tag);
      vec_t q[$];
      int   last_ph;
      int   outs  = 0;
      int   runs  = 0;
      int   seeds = 0;
      bit   live;
      live    = (n != 0) && (m != 0);
      last_ph = live ? m - 1 : 0;
      q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      if (live) begin
         for (int p = 0; p < m; p++) begin
            for (int k = 0; k < n; k++) q.push_back(mk(0, 1, 1, p >= sw, 0, 0, p));
            q.push_back(mk(0, 1, 0, 0, 0, 0, p));
         end
      end
      q.push_back(mk(0, 0, 0, 0, 1, 1, last_ph));
      N_CFG   = 8'(n);
      M_CFG   = 8'(m);
      SEED_SW = 8'(sw);
      START   = 1'b1;
      foreach (q[i]) begin
         @(negedge CLK);
         check_vec(tag, q[i]);
         outs  += int'(OUT);
         runs  += int'(RUNNING);
         seeds += int'(SEED);
         N_CFG   = 8'($urandom);
         M_CFG   = 8'($urandom);
         SEED_SW = 8'($urandom);
         if (i == q.size() - 1) START = 1'b1;
         else if (toggle) START = 1'($urandom_range(0, 1));
      end
      check_int({tag, "_out_cycles"}, outs, m * n);
      check_int({tag, "_run_cycles"}, runs, live ? m * (n + 1) : 0);
      check_int({tag, "_seed_cycles"}, seeds, (live && m > sw) ? n * (m - sw) : 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge CLK);
         check_vec({tag, "_hold"}, mk(0, 0, 0, 0, 0, 1, last_ph));
         if (h == hold - 1) START = 1'b0;
      end
      @(negedge CLK);
      check_vec({tag, "_wait"}, mk(0, 0, 0, 0, 0, 1, last_ph));
   endtask

   // Leaves the DUT at a negedge in ARM with START low.
   task automatic do_reset(input string tag);
      RESET = 1'b1;
      START = 1'b0;
      @(negedge CLK);
      check_vec({tag, "_in_reset"}, mk(0, 0, 0, 0, 0, 0, 0));
      RESET = 1'b0;
      @(negedge CLK);
      check_vec({tag, "_arm"}, mk(0, 0, 0, 0, 0, 0, 0));
   endtask

   initial begin
      RESET   = 1'b1;
      START   = 1'b0;
      N_CFG   = '0;
      M_CFG   = '0;
      SEED_SW = '0;
`ifdef BIST_ABORT_EN
      ABORT   = 1'b0;
`endif
      do_reset("por");

      session(3, 2, 0, 2, 1'b0, "basic");
      session(4, 6, 3, 1, 1'b1, "seed_sw");
      session(0, 5, 0, 1, 1'b1, "n_zero");
      session(4, 0, 0, 1, 1'b0, "m_zero");
      session(3, 2, 1, 5, 1'b0, "hold_long");
      session(3, 2, 1, 1, 1'b0, "rerun");

      // Reset in the fifth RUN cycle of an N=8, M=4 session.
      N_CFG   = 8'd8;
      M_CFG   = 8'd4;
      SEED_SW = 8'd0;
      START   = 1'b1;
      @(negedge CLK);
      check_vec("mid_init", mk(1, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         check_vec("mid_run", mk(0, 1, 1, 1, 0, 0, 0));
      end
      do_reset("mid_rst");
      session(2, 2, 1, 1, 1'b0, "post_rst");

      session(255, 2, 200, 1, 1'b0, "n_full");
      session(2, 255, 250, 1, 1'b1, "m_full");

      for (int r = 0; r < 12; r++) begin
         session(int'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 7)), int'($urandom_range(1, 3)),
                 1'($urandom_range(0, 1)), "rand");
      end

`ifdef BIST_ABORT_EN
      N_CFG   = 8'd3;
      M_CFG   = 8'd3;
      SEED_SW = 8'd0;
      START   = 1'b1;
      @(negedge CLK);
      check_vec("ab_init", mk(1, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         check_vec("ab_run0", mk(0, 1, 1, 1, 0, 0, 0));
      end
      @(negedge CLK);
      check_vec("ab_gap0", mk(0, 1, 0, 0, 0, 0, 0));
      @(negedge CLK);
      check_vec("ab_run1", mk(0, 1, 1, 1, 0, 0, 1));
      ABORT = 1'b1;
      @(negedge CLK);
      check_vec("ab_done", mk(0, 0, 0, 0, 1, 1, 1));
      check_int("ab_flag_done", int'(ABORTED), 1);
      ABORT = 1'b0;
      START = 1'b1;
      @(negedge CLK);
      check_vec("ab_hold", mk(0, 0, 0, 0, 0, 1, 1));
      check_int("ab_flag_hold", int'(ABORTED), 1);
      ABORT = 1'b1;
      START = 1'b0;
      @(negedge CLK);
      check_int("ab_flag_wait", int'(ABORTED), 1);
      ABORT = 1'b0;
      START = 1'b1;
      @(negedge CLK);
      check_vec("ab_reinit", mk(1, 0, 0, 0, 0, 0, 0));
      check_int("ab_flag_cleared", int'(ABORTED), 0);
      START = 1'b0;
      for (int k = 0; k < 3; k++) @(negedge CLK);
      check_int("ab_flag_stays_clear", int'(ABORTED), 0);
      do_reset("ab_rst");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bist_sequencer.md
BIST_SEQUENCER -- requirements
Module: bist_sequencer

Interface
REQ-001 Parameter CNT_W, default 8, bit width of the pattern counter, the phase counter and all config inputs.
REQ-002 Parameter SEED_SW_DEF, default 4, reset value of the internal seed-switch register.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-005 START  input  1  session request; a session starts on a 0->1 transition seen by the FSM.
REQ-006 N_CFG  input  CNT_W  patterns per phase.
REQ-007 M_CFG  input  CNT_W  phases per session.
REQ-008 SEED_SW  input  CNT_W  first phase index (0-based) that uses the alternate seed.
REQ-009 INIT  output  1  one-cycle pulse at session start.
REQ-010 RUNNING  output  1  high while the sequence executes.
REQ-011 OUT  output  1  pattern-apply enable.
REQ-012 SEED  output  1  alternate-seed select.
REQ-013 FINISH  output  1  one-cycle pulse at session end.
REQ-014 BIST_END  output  1  session-complete flag.
REQ-015 PHASE  output  CNT_W  current phase index.

Function
REQ-016 The FSM SHALL have these states: IDLE, ARM, INIT, RUN, GAP, DONE, HOLD, WAIT.
- IDLE: goes to ARM when START=0.
- ARM: goes to INIT when START=1.
- INIT: goes to RUN, or to DONE when the latched N or M is 0.
- RUN: goes to GAP after N latched cycles.
- GAP: goes to RUN when phase+1 < M, otherwise to DONE.
- DONE: goes to HOLD.
- HOLD: goes to WAIT when START=0.
- WAIT: goes to INIT when START=1.
REQ-017 In INIT, the block SHALL latch N_CFG, M_CFG and SEED_SW, and SHALL clear the pattern counter and PHASE to 0.
REQ-018 In RUN, OUT=1 and RUNNING=1, and the pattern counter SHALL increment from 0 to N-1.
REQ-019 In GAP (exactly 1 cycle), OUT=0 and RUNNING=1, the pattern counter SHALL clear, and PHASE SHALL increment on exit to RUN.
REQ-020 SEED SHALL be 1 only in RUN with PHASE >= the latched SEED_SW, and 0 otherwise.
REQ-021 Output decode by state:
- INIT=1 only in INIT.
- FINISH=1 only in DONE.
- BIST_END=1 in DONE, HOLD and WAIT.
- BIST_END=0 in all other states.
REQ-022 Latency: START first seen high in ARM or WAIT at edge k gives INIT in cycle k+1 and the first OUT in cycle k+2.
REQ-023 A session SHALL last exactly M*(N+1) RUNNING cycles and exactly M*N OUT cycles.
REQ-024 Counters SHALL compare with equality to the latched value minus 1, with no wrap. N=M=2^CNT_W-1 SHALL complete correctly.
REQ-025 Changes to N_CFG, M_CFG or SEED_SW after INIT SHALL have no effect until the next INIT.
REQ-026 START toggling during RUN or GAP SHALL be ignored. START held high through HOLD SHALL NOT restart the block.
REQ-027 An unreachable state encoding SHALL drive all outputs to 0 and move to IDLE on the next edge.

Reset
REQ-028 RESET=1 at a clock edge SHALL force state IDLE, clear both counters and PHASE, and load the seed-switch register with SEED_SW_DEF, regardless of the current state, including mid-RUN.
REQ-029 After reset, all 1-bit outputs SHALL be 0 and PHASE SHALL be 0 until the next state transition.

Configuration
REQ-030 With BIST_ABORT_EN defined, the block SHALL add input ABORT (1 bit) and output ABORTED (1 bit).
REQ-031 With BIST_ABORT_EN defined, ABORT=1 in RUN or GAP SHALL force DONE on the next edge and set ABORTED. ABORTED SHALL hold until the next INIT or RESET. ABORT SHALL have no effect in other states.
REQ-032 Without BIST_ABORT_EN, neither the ABORT port nor the ABORTED port SHALL exist, and the behaviour SHALL be as in REQ-016 to REQ-027.

Structure
REQ-033 A shared package bist_pkg SHALL hold the state enumeration (3 bits) and the default CNT_W and SEED_SW_DEF constants.
REQ-034 The pattern/phase counter pair SHALL be a sub-module bist_counter. It SHALL have inputs clr and en, inputs n_max and m_max, and outputs pat_last, phase_last and phase.
REQ-035 The FSM and output decode SHALL reside in bist_sequencer.

Verification
REQ-036 Reset, then START 0->1 with N=3, M=2 -> INIT 1 cycle, OUT pattern 1110 1110, FINISH 1 cycle, BIST_END=1, total RUNNING cycles = 8.
REQ-037 N=4, M=6, SEED_SW=3 -> SEED=1 only during the RUN cycles of PHASE 3, 4 and 5 (12 cycles).
REQ-038 N=0 or M=0 -> INIT then DONE on the next cycle with no OUT, and FINISH=1 for 1 cycle.
REQ-039 START held high after DONE -> the block stays in HOLD. START 0 then 1 -> a second session with identical output timing.
REQ-040 RESET asserted in cycle 5 of RUN (N=8, M=4) -> next cycle all outputs 0 and state IDLE, and a START 0->1 afterwards is accepted normally.
REQ-041 With BIST_ABORT_EN defined, ABORT pulse in PHASE 1 -> DONE next edge, FINISH=1, ABORTED=1 held through HOLD and cleared at the next INIT.
